// File: rtl/td4_core_if.sv
// td4_core_if: instruction-fetch bus between the TD4 core and its program ROM.
//   rom_addr : 4-bit instruction address, driven by the core (its PC)
//   rom_data : 8-bit instruction word, returned combinationally by the ROM
// Modports: master = core side, slave = ROM side.
interface td4_core_if;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;

   modport master (output rom_addr, input  rom_data);
   modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/td4_core.sv
// td4_core: TD4 4-bit CPU core. Fetches from a 16x8 ROM at PC, decodes
// {op[7:4], im[3:0]} and retires one instruction per clk edge with en=1.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (priority over en)
//   en              : step enable
//   rom             : fetch bus (master), rom_addr = PC
//   in_port         : 4-bit input port, sampled at the executing edge
//   out_port        : 4-bit output port register
//   dbg_a/b/carry/pc: architectural state for observation
module td4_core #(
   parameter logic [3:0] RESET_PC  = 4'h0,
   parameter logic [3:0] OUT_RESET = 4'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   td4_core_if.master       rom,
   input  logic [3:0]       in_port,
   output logic [3:0]       out_port,
   output logic [3:0]       dbg_a,
   output logic [3:0]       dbg_b,
   output logic             dbg_carry,
   output logic [3:0]       dbg_pc
);

   logic [3:0] pc_q, pc_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] out_q, out_d;
   logic       c_q;

   logic [3:0] op, im;
   logic [3:0] src, addend;
   logic [4:0] sum;

   assign op = rom.rom_data[7:4];
   assign im = rom.rom_data[3:0];

   // Every instruction routes through the adder: moves/in/out add 0 or use a
   // zero source, so the same sum feeds every destination and its bit 4 is the
   // new carry (always 0 for non-add instructions).
   always_comb begin
      src    = 4'h0;
      addend = 4'h0;
      case (op)
         4'b0000: begin src = a_q; addend = im; end  // add a,im
         4'b0001: src = b_q;                         // mov a,b
         4'b0010: src = in_port;                     // in a
         4'b0011: addend = im;                       // mov a,im
         4'b0100: src = a_q;                         // mov b,a
         4'b0101: begin src = b_q; addend = im; end  // add b,im
         4'b0110: src = in_port;                     // in b
         4'b0111: addend = im;                       // mov b,im
         4'b1001: src = b_q;                         // out b
         4'b1011: addend = im;                       // out im
         4'b1110: addend = im;                       // jnc im
         4'b1111: addend = im;                       // jmp im
         default: ;                                  // undefined: NOP
      endcase
   end

   assign sum = {1'b0, src} + {1'b0, addend};

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      out_d = out_q;
      pc_d  = pc_q + 4'd1;
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011: a_d   = sum[3:0];
         4'b0100, 4'b0101, 4'b0110, 4'b0111: b_d   = sum[3:0];
         4'b1001, 4'b1011:                   out_d = sum[3:0];
         // jnc looks at the carry left by the previous instruction, not the
         // one being produced on this edge.
         4'b1110: if (!c_q) pc_d = sum[3:0];
         4'b1111: pc_d = sum[3:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         a_q   <= 4'h0;
         b_q   <= 4'h0;
         c_q   <= 1'b0;
         out_q <= OUT_RESET;
      end else if (en) begin
         pc_q  <= pc_d;
         a_q   <= a_d;
         b_q   <= b_d;
         c_q   <= sum[4];
         out_q <= out_d;
      end
   end

   assign rom.rom_addr = pc_q;
   assign out_port     = out_q;
   assign dbg_a        = a_q;
   assign dbg_b        = b_q;
   assign dbg_carry    = c_q;
   assign dbg_pc       = pc_q;

endmodule

// File: tb/tb_td4_core.sv
// tb_td4_core: directed programs for td4_core. The stimulus process pushes
// the hand-derived architectural state expected after each clk edge; a
// negedge monitor pops and compares whenever an expectation is pending.
module tb_td4_core;
   typedef struct packed {
      logic [3:0] pc;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] o;
      logic       c;
   } st_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [3:0] in_port = 4'h0;
   logic [3:0] out_port, dbg_a, dbg_b, dbg_pc;
   logic       dbg_carry;
   logic [7:0] rom [16];

   st_t   exp_q [$];
   string nm_q  [$];
   int    total = 0;
   int    bad   = 0;

   td4_core_if bus ();
   assign bus.rom_data = rom[bus.rom_addr];

   td4_core #(.RESET_PC(4'h0), .OUT_RESET(4'h0)) dut (
      .clk(clk), .rst(rst), .en(en), .rom(bus), .in_port(in_port),
      .out_port(out_port), .dbg_a(dbg_a), .dbg_b(dbg_b),
      .dbg_carry(dbg_carry), .dbg_pc(dbg_pc)
   );

   always #5 clk = ~clk;

   // Monitor: compare state after the edge that produced each expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         st_t   e, act;
         string n;
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         act = '{pc: dbg_pc, a: dbg_a, b: dbg_b, o: out_port, c: dbg_carry};
         total++;
         if (act !== e || bus.rom_addr !== e.pc) begin
            bad++;
            $display("FAIL %s: got pc=%h a=%h b=%h out=%h c=%b addr=%h, want pc=%h a=%h b=%h out=%h c=%b",
                     n, act.pc, act.a, act.b, act.o, act.c, bus.rom_addr,
                     e.pc, e.a, e.b, e.o, e.c);
         end
      end
   end

   task automatic step(input logic e_i, input logic r_i, input string n,
                       input logic [3:0] pc, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] o, input logic c);
      en  = e_i;
      rst = r_i;
      @(posedge clk);
      exp_q.push_back('{pc: pc, a: a, b: b, o: o, c: c});
      nm_q.push_back(n);
      #1;
   endtask

   task automatic load(input logic [7:0] p [16]);
      for (int i = 0; i < 16; i++) rom[i] = p[i];
   endtask

   logic [7:0] prog [16];

   initial begin
      // ---------------- counter program ----------------
      prog = '{default: 8'hF4};
      prog[0] = 8'h70; prog[1] = 8'h90; prog[2] = 8'h51; prog[3] = 8'hF1;
      prog[4] = 8'hF4;
      load(prog);
      step(1'b0, 1'b1, "reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "cnt_movb0", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
      for (int k = 0; k <= 16; k++) begin
         logic [3:0] kb, kn;
         kb = k[3:0];
         kn = kb + 4'd1;
         step(1'b1, 1'b0, "cnt_out", 4'h2, 4'h0, kb, kb, 1'b0);
         if (k == 5) begin
            step(1'b0, 1'b0, "cnt_hold0", 4'h2, 4'h0, kb, kb, 1'b0);
            step(1'b0, 1'b0, "cnt_hold1", 4'h2, 4'h0, kb, kb, 1'b0);
         end
         step(1'b1, 1'b0, "cnt_add", 4'h3, 4'h0, kn, kb, (k == 15));
         step(1'b1, 1'b0, "cnt_jmp", 4'h1, 4'h0, kn, kb, 1'b0);
      end

      // ---------------- reset mid-run (B=7, PC=2) ----------------
      step(1'b1, 1'b1, "rst_pre", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "rst_movb0", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
      for (int k = 0; k < 7; k++) begin
         logic [3:0] kb, kn;
         kb = k[3:0];
         kn = kb + 4'd1;
         step(1'b1, 1'b0, "rst_out", 4'h2, 4'h0, kb, kb, 1'b0);
         step(1'b1, 1'b0, "rst_add", 4'h3, 4'h0, kn, kb, 1'b0);
         step(1'b1, 1'b0, "rst_jmp", 4'h1, 4'h0, kn, kb, 1'b0);
      end
      step(1'b1, 1'b0, "rst_out7", 4'h2, 4'h0, 4'h7, 4'h7, 1'b0);
      step(1'b1, 1'b1, "rst_mid", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "rst_restart0", 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "rst_restart1", 4'h2, 4'h0, 4'h0, 4'h0, 1'b0);

      // ---------------- jnc not taken ----------------
      prog = '{default: 8'hF4};
      prog[0] = 8'h3F; prog[1] = 8'h01; prog[2] = 8'hE0; prog[3] = 8'hB5;
      load(prog);
      step(1'b0, 1'b1, "jnc1_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "jnc1_mova", 4'h1, 4'hF, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "jnc1_add", 4'h2, 4'h0, 4'h0, 4'h0, 1'b1);
      step(1'b1, 1'b0, "jnc1_fall", 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "jnc1_out5", 4'h4, 4'h0, 4'h0, 4'h5, 1'b0);
      step(1'b1, 1'b0, "jnc1_halt", 4'h4, 4'h0, 4'h0, 4'h5, 1'b0);

      // ---------------- jnc taken ----------------
      prog[1] = 8'h00;
      load(prog);
      step(1'b0, 1'b1, "jnc2_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "jnc2_mova", 4'h1, 4'hF, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "jnc2_add0", 4'h2, 4'hF, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "jnc2_taken", 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "jnc2_again", 4'h1, 4'hF, 4'h0, 4'h0, 1'b0);

      // ---------------- in_port ----------------
      prog = '{default: 8'hF3};
      prog[0] = 8'h20; prog[1] = 8'h40; prog[2] = 8'h90;
      load(prog);
      in_port = 4'hA;
      step(1'b0, 1'b1, "in_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "in_a", 4'h1, 4'hA, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "in_movba", 4'h2, 4'hA, 4'hA, 4'h0, 1'b0);
      step(1'b1, 1'b0, "in_outb", 4'h3, 4'hA, 4'hA, 4'hA, 1'b0);
      in_port = 4'h6;
      prog[3] = 8'h60;  // in b
      load(prog);
      step(1'b1, 1'b0, "in_b", 4'h4, 4'hA, 4'h6, 4'hA, 1'b0);

      // ---------------- undefined opcodes / PC wrap ----------------
      prog = '{default: 8'hF0};
      prog[0] = 8'h33; prog[1] = 8'h7F; prog[2] = 8'hB9; prog[3] = 8'h51;
      prog[4] = 8'h80; prog[5] = 8'hC1; prog[6] = 8'hD2; prog[7] = 8'hFF;
      prog[15] = 8'hA7;
      load(prog);
      step(1'b0, 1'b1, "nop_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "nop_mova3", 4'h1, 4'h3, 4'h0, 4'h0, 1'b0);
      step(1'b1, 1'b0, "nop_movbF", 4'h2, 4'h3, 4'hF, 4'h0, 1'b0);
      step(1'b1, 1'b0, "nop_out9", 4'h3, 4'h3, 4'hF, 4'h9, 1'b0);
      step(1'b1, 1'b0, "nop_ovf", 4'h4, 4'h3, 4'h0, 4'h9, 1'b1);
      step(1'b1, 1'b0, "nop_1000", 4'h5, 4'h3, 4'h0, 4'h9, 1'b0);
      step(1'b1, 1'b0, "nop_1100", 4'h6, 4'h3, 4'h0, 4'h9, 1'b0);
      step(1'b1, 1'b0, "nop_1101", 4'h7, 4'h3, 4'h0, 4'h9, 1'b0);
      step(1'b1, 1'b0, "nop_jmpF", 4'hF, 4'h3, 4'h0, 4'h9, 1'b0);
      step(1'b1, 1'b0, "nop_wrap", 4'h0, 4'h3, 4'h0, 4'h9, 1'b0);
      step(1'b1, 1'b0, "nop_rerun", 4'h1, 4'h3, 4'h0, 4'h9, 1'b0);

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/td4_core.md
Name: td4_core

Overview:
- TD4 4-bit CPU core: the consumer of the 16x8 program ROM.
- Drives the ROM address from its program counter and decodes the returned 8-bit instruction word (upper nibble opcode, lower nibble immediate).
- Executes one instruction per enabled clock, updating A/B registers, carry flag, PC and the 4-bit output port.
- Sits between the ROM and the board-level I/O (switches into in_port, LEDs from out_port).

Parameters:
- RESET_PC, 4'h0, PC value loaded on reset.
- OUT_RESET, 4'h0, out_port value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step enable; an instruction retires only on a clk edge with en=1.
- rom_addr  output  4  instruction address to ROM; equals PC.
- rom_data  input  8  instruction from ROM; combinational function of rom_addr.
- in_port  input  4  input port, sampled at the executing edge.
- out_port  output  4  output port register.
- dbg_a  output  4  register A.
- dbg_b  output  4  register B.
- dbg_carry  output  1  carry flag.
- dbg_pc  output  4  PC (same value as rom_addr).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst.
- Reset: on a clk edge with rst=1, PC=RESET_PC, A=0, B=0, carry=0, out_port=OUT_RESET. rst has priority over en. Reset mid-program abandons the current instruction with no partial update.
- Timing:
  - Single-cycle execution. rom_addr=PC combinationally; the instruction at PC executes at the next clk edge with en=1.
  - en=0: all state holds, and rom_addr stays stable.
- Adder:
  - 5-bit sum = {0,src} + {0,imm}; the result is sum[3:0].
  - carry := sum[4] on every retired instruction. Non-add instructions therefore produce carry=0, because their imm or src contribution gives no overflow. Specifically, mov/in/out/jmp/jnc add imm=0 or src=0 and so clear carry.
- Opcodes (op=rom_data[7:4], im=rom_data[3:0]):
  - 0000 add a,im: A := A+im.
  - 0001 mov a,b: A := B.
  - 0010 in a: A := in_port.
  - 0011 mov a,im: A := im.
  - 0100 mov b,a: B := A.
  - 0101 add b,im: B := B+im.
  - 0110 in b: B := in_port.
  - 0111 mov b,im: B := im.
  - 1001 out b: out_port := B.
  - 1011 out im: out_port := im.
  - 1110 jnc im: PC := im if carry==0 (the value before this edge), else PC+1.
  - 1111 jmp im: PC := im.
  - 1000, 1010, 1100, 1101 are undefined and execute as NOP: no register or port change, carry := 0, PC := PC+1.
- PC:
  - PC := PC+1 mod 16 unless a jump is taken; 15 wraps to 0.
  - jmp to the current PC is a legal halt loop.
- Overflow: 4-bit results wrap (B=15, add b,1 gives B=0 and carry=1).
- Carry timing: jnc tests the carry produced by the immediately preceding retired instruction. Because of that, the same-cycle carry update does not affect the branch decision.
- Output port: out_port changes only on out b or out im.

Test Plan:
- Counter program (mov b,0 / out b / add b,1 / jmp 1 / jmp 4), en=1 -> out_port steps 0,1,...,15,0 every 3 cycles after the first out. At the add making B 15->0, carry=1 for one instruction, then jmp clears it.
- jnc taken/not taken: mov a,15 / add a,1 / jnc 0 / out im 5 -> carry=1, PC falls through to 3, out_port=5. Repeat with add a,0 -> jnc jumps back to 0.
- in_port: in_port=4'hA, in a / mov b,a / out b -> dbg_a=A, dbg_b=A, out_port=A after 3 enabled edges.
- en gating: toggle en 1,0,0,1 during the counter program -> state frozen on en=0 edges. Trace equals the en=1 trace with idle cycles inserted.
- Reset mid-run: assert rst for 1 cycle with en=1 while B=7 and PC=2 -> next cycle PC=0, A=B=0, carry=0, out_port=0. Program restarts cleanly.
- Undefined opcode 1000 after an overflowing add -> carry cleared, PC+1, A/B/out_port unchanged. PC wraps from 15 to 0 on a NOP at address 15.
